scr1_tb_ahb_mem_mport: RTL and testbench

- Parametrised multi-port AHB-Lite slave memory model for the core testbenches; successor to the fixed two-interface (imem/dmem) test memory.
- Serves NPORTS independent AHB-Lite ports onto one shared byte-addressed array.
- Each port has its own programmable wait-state count and its own error region.
- Adds ERROR responses and per-port error counters.

---
 rtl/scr1_tb_ahb_mem_mport_if.sv | 19 +
 rtl/scr1_tb_ahb_mem_mport.sv | 152 +++++++++++++++
 tb/tb_scr1_tb_ahb_mem_mport.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tb_ahb_mem_mport_if.sv
// AHB-Lite bus bundle for the multi-port test memory: one packed slice per port.
interface scr1_tb_ahb_mem_mport_if #(
   parameter int NPORTS = 2,
   parameter int DATA_W = 32
);
   logic [NPORTS-1:0][2:0]        hsize;
   logic [NPORTS-1:0][1:0]        htrans;
   logic [NPORTS-1:0][31:0]       haddr;
   logic [NPORTS-1:0]             hwrite;
   logic [NPORTS-1:0][DATA_W-1:0] hwdata;
   logic [NPORTS-1:0]             hready;
   logic [NPORTS-1:0][DATA_W-1:0] hrdata;
   logic [NPORTS-1:0]             hresp;

   modport master (output hsize, htrans, haddr, hwrite, hwdata,
                   input  hready, hrdata, hresp);
   modport slave  (input  hsize, htrans, haddr, hwrite, hwdata,
                   output hready, hrdata, hresp);
endinterface

// File: rtl/scr1_tb_ahb_mem_mport.sv
// Multi-port AHB-Lite slave test memory: NPORTS ports share one byte array,
// each with its own wait-state count, ERROR responses and error counter.
module scr1_tb_ahb_mem_mport_lane #(
   parameter int          AW       = 16,
   parameter int          LB       = 2,
   parameter int          STALL_W  = 4,
   parameter logic [31:0] ERR_BASE = 32'hFFFF_0000,
   parameter logic [31:0] ERR_MASK = 32'hFFFF_0000
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [STALL_W-1:0]  stall,
   input  logic [1:0]          htrans,
   input  logic [2:0]          hsize,
   input  logic [31:0]         haddr,
   input  logic                hwrite,
   output logic                hready,
   output logic                hresp,
   output logic [15:0]         err_cnt,
   output logic                beat_rd,
   output logic                beat_wr,
   output logic [(1<<LB)-1:0]  sel,
   output logic [AW-1:0]       addr
);
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_OKAY, ST_ERR1, ST_ERR2} state_t;

   state_t             state, state_nxt;
   logic [STALL_W-1:0] cnt;
   logic [2:0]         size;
   logic               write;
   logic               cap, err;
   logic               unused_htrans;

   assign unused_htrans = htrans[0];
   assign cap = hready & htrans[1];
   assign err = ((haddr & ERR_MASK) == ERR_BASE) | (hsize > 3'(LB))
              | ((haddr & ((32'd1 << hsize) - 32'd1)) != 32'd0);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_WAIT: if (cnt == STALL_W'(1)) state_nxt = ST_OKAY;
         ST_ERR1: state_nxt = ST_ERR2;
         default: begin
            // IDLE, OKAY and ERR2 all leave hready high, so they share the capture decision
            if (!cap)                     state_nxt = ST_IDLE;
            else if (err)                 state_nxt = ST_ERR1;
            else if (stall == '0)         state_nxt = ST_OKAY;
            else                          state_nxt = ST_WAIT;
         end
      endcase
   end

   always_comb begin
      hready  = 1'b1;
      hresp   = 1'b0;
      beat_rd = 1'b0;
      beat_wr = 1'b0;
      unique case (state)
         ST_WAIT: hready = 1'b0;
         ST_ERR1: begin hready = 1'b0; hresp = 1'b1; end
         ST_ERR2: hresp = 1'b1;
         ST_OKAY: begin beat_rd = ~write; beat_wr = write; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         addr  <= '0;
         size  <= '0;
         write <= 1'b0;
      end else if (cap) begin
         cnt   <= stall;
         addr  <= haddr[AW-1:0];
         size  <= hsize;
         write <= hwrite;
      end else if (state == ST_WAIT) begin
         cnt <= cnt - 1'b1;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                                  err_cnt <= '0;
      else if (state == ST_ERR2 && err_cnt != '1)  err_cnt <= err_cnt + 16'd1;

   // Only aligned, in-range sizes reach OKAY, so the lane window never crosses the bus word
   always_comb begin
      sel = '0;
      for (int l = 0; l < (1 << LB); l++)
         sel[l] = (l >= int'(addr[LB-1:0])) && (l < int'(addr[LB-1:0]) + (1 << size));
   end
endmodule

module scr1_tb_ahb_mem_mport #(
   parameter int          NPORTS         = 2,
   parameter int          DATA_W         = 32,
   parameter int          MEM_POWER_SIZE = 16,
   parameter logic [31:0] ERR_BASE       = 32'hFFFF_0000,
   parameter logic [31:0] ERR_MASK       = 32'hFFFF_0000,
   parameter int          STALL_W        = 4
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NPORTS-1:0][STALL_W-1:0]  stall_in,
   scr1_tb_ahb_mem_mport_if.slave          bus,
   output logic [NPORTS-1:0][15:0]         err_cnt
);
   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   logic [7:0] mem [0:(1<<MEM_POWER_SIZE)-1];

   logic [NPORTS-1:0]                              beat_rd, beat_wr, hready, hresp;
   logic [NPORTS-1:0][NB-1:0]                      sel, we;
   logic [NPORTS-1:0][MEM_POWER_SIZE-1:0]          addr;
   logic [NPORTS-1:0][NB-1:0][MEM_POWER_SIZE-1:0]  idx;
   logic [NPORTS-1:0][NB-1:0][7:0]                 rdata;

   assign bus.hready = hready;
   assign bus.hresp  = hresp;

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      scr1_tb_ahb_mem_mport_lane #(
         .AW(MEM_POWER_SIZE), .LB(LB), .STALL_W(STALL_W),
         .ERR_BASE(ERR_BASE), .ERR_MASK(ERR_MASK)
      ) u_lane (
         .clk(clk), .rst_n(rst_n), .stall(stall_in[p]),
         .htrans(bus.htrans[p]), .hsize(bus.hsize[p]), .haddr(bus.haddr[p]),
         .hwrite(bus.hwrite[p]), .hready(hready[p]), .hresp(hresp[p]),
         .err_cnt(err_cnt[p]), .beat_rd(beat_rd[p]), .beat_wr(beat_wr[p]),
         .sel(sel[p]), .addr(addr[p])
      );
      for (genvar l = 0; l < NB; l++) begin : g_byte
         assign idx[p][l]   = {addr[p][MEM_POWER_SIZE-1:LB], LB'(l)};
         assign we[p][l]    = beat_wr[p] & sel[p][l];
         // Reads see the array before this edge's writes from any port
         assign rdata[p][l] = (beat_rd[p] & sel[p][l]) ? mem[idx[p][l]] : 8'h00;
      end
      assign bus.hrdata[p] = rdata[p];
   end

   // Ascending port order: the highest port's write to a shared byte lands last
   always_ff @(posedge clk)
      for (int p = 0; p < NPORTS; p++)
         for (int l = 0; l < NB; l++)
            if (we[p][l]) mem[idx[p][l]] <= bus.hwdata[p][8*l +: 8];
endmodule

// File: tb/tb_scr1_tb_ahb_mem_mport.sv
// Randomised scoreboard bench for the multi-port AHB test memory.
module tb_scr1_tb_ahb_mem_mport;
   localparam int NPORTS = 2;
   localparam int DATA_W = 32;
   localparam int STALL_W = 4;

   typedef struct {
      bit          rd;
      bit          err;
      int          waits;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [NPORTS-1:0][STALL_W-1:0] stall_in;
   logic [NPORTS-1:0][15:0]        err_cnt;

   scr1_tb_ahb_mem_mport_if #(.NPORTS(NPORTS), .DATA_W(DATA_W)) bus ();

   scr1_tb_ahb_mem_mport #(.NPORTS(NPORTS), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .bus(bus), .err_cnt(err_cnt));

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic [7:0] mdl [0:65535];
   exp_t exp_q [NPORTS][$];
   int   exp_err [NPORTS];
   bit   in_dp [NPORTS];
   int   lows [NPORTS];
   exp_t cur [NPORTS];

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: byte-level view of each transfer, computed when it is issued
   function automatic void expect_x(int p, bit wr, logic [31:0] a, logic [2:0] sz,
                                    logic [31:0] wd, int st, bit apply);
      exp_t e;
      int lane, m;
      e.rd    = !wr;
      e.err   = ((a & 32'hFFFF_0000) == 32'hFFFF_0000) || (sz > 3'd2)
                || ((a % (32'd1 << sz)) != 0);
      e.waits = e.err ? 1 : st;
      e.data  = '0;
      if (e.err) exp_err[p]++;
      else
         for (int i = 0; i < (1 << sz); i++) begin
            lane = int'(a % 4) + i;
            m    = int'((a + 32'(i)) & 32'hFFFF);
            if (wr) begin
               if (apply) mdl[m] = wd[8*lane +: 8];
            end else e.data[8*lane +: 8] = mdl[m];
         end
      exp_q[p].push_back(e);
   endfunction

   task automatic drive(int p, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd, int st);
      bit rdy;
      int n = 0;
      bus.htrans[p] = 2'b10;
      bus.haddr[p]  = a;
      bus.hsize[p]  = sz;
      bus.hwrite[p] = wr;
      stall_in[p]   = STALL_W'(st);
      do begin
         @(negedge clk);
         rdy = bus.hready[p];
         @(posedge clk);
         n++;
      end while (!rdy && n < 100);
      if (!rdy) begin
         errors++;
         $display("FAIL accept_timeout p%0d: got no hready expected hready within 100 cycles", p);
      end
      #1;
      bus.htrans[p] = 2'b00;
      bus.hwdata[p] = wd;
      stall_in[p]   = STALL_W'($urandom);  // must not disturb the transfer in flight
   endtask

   task automatic xfer(int p, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd, int st);
      expect_x(p, wr, a, sz, wd, st, 1'b1);
      drive(p, wr, a, sz, wd, st);
   endtask

   task automatic drain(int p);
      int n = 0;
      while ((in_dp[p] || exp_q[p].size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         errors++;
         $display("FAIL drain_timeout p%0d: got busy port expected idle", p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_xfer(int p);
      logic [31:0] a;
      logic [2:0]  sz;
      int r;
      r  = $urandom_range(0, 19);
      sz = (r == 0) ? 3'd3 : (r == 1) ? 3'd5 : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 'h3FF));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      r = $urandom_range(0, 9);
      if (r == 0)      a = a | 32'hFFFF_0000;
      else if (r == 1) a = a | {16'($urandom_range(1, 'hFFFE)), 16'h0};
      xfer(p, 1'($urandom), a, sz, $urandom, $urandom_range(0, 3));
   endtask

   task automatic chk_errcnt(string tag);
      for (int p = 0; p < NPORTS; p++)
         chk($sformatf("%s err_cnt p%0d", tag, p), 64'(err_cnt[p]),
             64'((exp_err[p] > 65535) ? 65535 : exp_err[p]));
   endtask

   // Monitor: follows each port's data phase and pops the expected response
   initial forever begin
      @(negedge clk);
      for (int p = 0; p < NPORTS; p++) begin
         if (!mon_en || !rst_n) in_dp[p] = 1'b0;
         else begin
            if (in_dp[p] && !bus.hready[p]) begin
               lows[p]++;
               chk($sformatf("p%0d wait hresp/hrdata", p),
                   {31'h0, bus.hresp[p], bus.hrdata[p]}, {31'h0, cur[p].err, 32'h0});
            end else if (in_dp[p]) begin
               chk($sformatf("p%0d wait cycles", p), 64'(lows[p]), 64'(cur[p].waits));
               chk($sformatf("p%0d hresp", p), 64'(bus.hresp[p]), 64'(cur[p].err));
               chk($sformatf("p%0d hrdata", p), 64'(bus.hrdata[p]),
                   64'((cur[p].rd && !cur[p].err) ? cur[p].data : 32'h0));
               in_dp[p] = 1'b0;
            end else begin
               chk($sformatf("p%0d idle outputs", p),
                   {bus.hready[p], bus.hresp[p], bus.hrdata[p]}, {1'b1, 1'b0, 32'h0});
            end
            if (bus.hready[p] && bus.htrans[p][1]) begin
               if (exp_q[p].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_xfer p%0d: got transfer expected none", p);
               end else begin
                  cur[p]   = exp_q[p].pop_front();
                  in_dp[p] = 1'b1;
                  lows[p]  = 0;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1;
      bus.htrans = '0; bus.haddr = '0; bus.hsize = '0; bus.hwrite = '0; bus.hwdata = '0;
      stall_in = '0;
      for (int p = 0; p < NPORTS; p++) exp_err[p] = 0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset hready", 64'(bus.hready), 64'({NPORTS{1'b1}}));
      chk("reset hresp", 64'(bus.hresp), 64'h0);
      chk("reset hrdata", 64'(bus.hrdata), 64'h0);
      chk("reset err_cnt", 64'(err_cnt), 64'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Known contents for the working window 0x000-0x3FF, back-to-back on port 0
      for (int a = 0; a < 'h400; a += 4) xfer(0, 1'b1, 32'(a), 3'd2, $urandom, 0);
      xfer(0, 1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, 0);
      xfer(0, 1'b0, 32'h100, 3'd2, 32'h0, 0);
      drain(0);
      xfer(1, 1'b0, 32'h100, 3'd2, 32'h0, 3);
      drain(1);
      xfer(1, 1'b1, 32'h101, 3'd0, 32'h0000_5A00, 0);
      xfer(1, 1'b0, 32'h100, 3'd2, 32'h0, 1);
      xfer(1, 1'b0, 32'hFFFF_0004, 3'd2, 32'h0, 0);
      xfer(1, 1'b1, 32'h103, 3'd1, 32'hAAAA_AAAA, 2);
      xfer(1, 1'b0, 32'h100, 3'd2, 32'h0, 0);
      drain(1);
      chk_errcnt("directed");

      // Same-edge writes from both ports, then read-vs-write on one edge
      drain(0);
      expect_x(0, 1'b1, 32'h200, 3'd2, 32'h1111_1111, 0, 1'b1);
      expect_x(1, 1'b1, 32'h200, 3'd2, 32'h2222_2222, 0, 1'b1);
      fork
         drive(0, 1'b1, 32'h200, 3'd2, 32'h1111_1111, 0);
         drive(1, 1'b1, 32'h200, 3'd2, 32'h2222_2222, 0);
      join
      drain(0); drain(1);
      expect_x(0, 1'b0, 32'h200, 3'd2, 32'h0, 0, 1'b1);
      expect_x(1, 1'b1, 32'h200, 3'd2, 32'h3333_3333, 0, 1'b1);
      fork
         drive(0, 1'b0, 32'h200, 3'd2, 32'h0, 0);
         drive(1, 1'b1, 32'h200, 3'd2, 32'h3333_3333, 0);
      join
      drain(0); drain(1);
      xfer(0, 1'b0, 32'h200, 3'd2, 32'h0, 0);
      drain(0);

      begin
         int p = 0;
         repeat (400) begin
            if ($urandom_range(0, 7) == 0) begin
               drain(p);
               p = $urandom_range(0, NPORTS - 1);
            end
            rand_xfer(p);
         end
         drain(p);
      end
      chk_errcnt("random");

      // Reset during the wait states of a write: it must be dropped
      mon_en = 1'b0;
      drive(0, 1'b1, 32'h300, 3'd2, 32'hCAFE_F00D, 5);
      @(posedge clk); #1;
      chk("pre-reset hready p0", 64'(bus.hready[0]), 64'h0);
      rst_n = 1'b0;
      #1;
      chk("async reset hready", 64'(bus.hready), 64'({NPORTS{1'b1}}));
      chk("async reset hresp", 64'(bus.hresp), 64'h0);
      chk("async reset err_cnt", 64'(err_cnt), 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int p = 0; p < NPORTS; p++) exp_err[p] = 0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      xfer(0, 1'b0, 32'h300, 3'd2, 32'h0, 0);
      xfer(1, 1'b0, 32'h100, 3'd2, 32'h0, 2);
      drain(0); drain(1);
      chk_errcnt("post-reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
